// File: rtl/event_pulse_stretcher.sv
// Turns 1-cycle event strobes into fixed-width pulses separated by a guaranteed low gap.
// Events arriving mid-pulse are counted and replayed; excess events set a sticky overflow flag.
module event_pulse_stretcher #(
    parameter int unsigned HIGH_CYCLES = 50000,
    parameter int unsigned LOW_CYCLES  = 50000,
    parameter int unsigned COUNT_WIDTH = 16,
    parameter int unsigned PEND_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  strobe,
    input  logic                  clr_overflow,
    output logic                  pulse,
    output logic                  busy,
    output logic [PEND_WIDTH-1:0] pending,
    output logic                  overflow
);

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    localparam logic [COUNT_WIDTH-1:0] HighLoad = COUNT_WIDTH'(HIGH_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] LowLoad  = COUNT_WIDTH'(LOW_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] TimerOne = COUNT_WIDTH'(1);
    localparam logic [PEND_WIDTH-1:0]  PendOne  = PEND_WIDTH'(1);
    localparam logic [PEND_WIDTH-1:0]  PendMax  = {PEND_WIDTH{1'b1}};

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] timer_q, timer_d;
    logic [PEND_WIDTH-1:0]  pend_q, pend_d;
    logic                   sticky_q, sticky_d;
    logic                   pulse_q, pulse_d;
    logic                   busy_q, busy_d;
    logic                   overflow_q, overflow_d;

    logic final_low;
    logic has_event;
    logic consume;
    logic drop;

    always_comb begin
        final_low = (state_q == StLow) && (timer_q == '0);
        has_event = strobe || (pend_q != '0);
        consume   = ((state_q == StIdle) || final_low) && has_event;
        drop      = strobe && !consume && (pend_q == PendMax);
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            StIdle: begin
                if (consume) begin
                    state_d = StHigh;
                    timer_d = HighLoad;
                end
            end
            StHigh: begin
                if (timer_q == '0) begin
                    state_d = StLow;
                    timer_d = LowLoad;
                end else begin
                    timer_d = timer_q - TimerOne;
                end
            end
            StLow: begin
                if (timer_q == '0) begin
                    // Restart straight from the last low cycle so the event period stays exact.
                    if (consume) begin
                        state_d = StHigh;
                        timer_d = HighLoad;
                    end else begin
                        state_d = StIdle;
                        timer_d = '0;
                    end
                end else begin
                    timer_d = timer_q - TimerOne;
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        pend_d = pend_q;
        // A strobe consumed in the same cycle bypasses the queue.
        if (strobe && !consume && !drop) begin
            pend_d = pend_q + PendOne;
        end else if (consume && !strobe) begin
            pend_d = pend_q - PendOne;
        end
        sticky_d   = drop | (sticky_q & ~clr_overflow);
        pulse_d    = (state_q == StHigh);
        busy_d     = (state_q != StIdle);
        overflow_d = sticky_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            pend_q     <= '0;
            sticky_q   <= 1'b0;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pend_q     <= pend_d;
            sticky_q   <= sticky_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign pulse    = pulse_q;
    assign busy     = busy_q;
    assign pending  = pend_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_event_pulse_stretcher.sv
// Directed bench for event_pulse_stretcher with HIGH=3, LOW=2, PEND_WIDTH=2.
// Each step queues the expected outputs after the coming edge, then pops and checks them.
module tb_event_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       strobe = 1'b0;
    logic       clr_overflow = 1'b0;
    logic       pulse;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    typedef struct packed {
        logic       p;
        logic       b;
        logic [1:0] pd;
        logic       o;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   step_no = 0;

    event_pulse_stretcher #(
        .HIGH_CYCLES(3),
        .LOW_CYCLES (2),
        .COUNT_WIDTH(4),
        .PEND_WIDTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .strobe      (strobe),
        .clr_overflow(clr_overflow),
        .pulse       (pulse),
        .busy        (busy),
        .pending     (pending),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] want);
        n_total++;
        assert (got === want) n_pass++;
        else $error("FAIL %s step %0d: observed %0d expected %0d", tag, step_no, got, want);
    endtask

    task automatic step(input logic s, input logic c, input logic r,
                        input logic ep, input logic eb, input logic [1:0] epd, input logic eo);
        exp_t e;
        strobe       = s;
        clr_overflow = c;
        rst          = r;
        exp_q.push_back('{p: ep, b: eb, pd: epd, o: eo});
        @(posedge clk);
        #1;
        step_no++;
        e = exp_q.pop_front();
        chk("pulse", {3'b0, pulse}, {3'b0, e.p});
        chk("busy", {3'b0, busy}, {3'b0, e.b});
        chk("pending", {2'b0, pending}, {2'b0, e.pd});
        chk("overflow", {3'b0, overflow}, {3'b0, e.o});
    endtask

    // One strobe from idle: 3 high cycles, 2 low, then idle.
    task automatic single_pulse(input logic ov);
        step(1, 0, 0, 0, 0, 0, ov);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0, ov);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 1, 0, ov);
        step(0, 0, 0, 0, 0, 0, ov);
    endtask

    // Five strobes from idle: first consumed, three queued, fifth dropped.
    task automatic run_overflow(input logic clr_on_drop);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 1, 0);
        step(1, 0, 0, 1, 1, 2, 0);
        step(1, 0, 0, 1, 1, 3, 0);
        step(1, clr_on_drop, 0, 0, 1, 3, 0);
        step(0, 0, 0, 0, 1, 2, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 2, 1);
        step(0, 0, 0, 0, 1, 2, 1);
        step(0, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 1, 1);
        step(0, 0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0, 1);
        step(0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        // Reset state
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Single event
        single_pulse(1'b0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Three back-to-back events drain in order with continuous busy
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 1, 0);
        step(1, 0, 0, 1, 1, 2, 0);
        step(0, 0, 0, 1, 1, 2, 0);
        step(0, 0, 0, 0, 1, 2, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 1, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Overflow on a full queue
        run_overflow(1'b0);

        // Clear alone
        step(0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);

        // Clear coinciding with a new drop: set wins
        run_overflow(1'b1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Seamless restart on the final low cycle
        step(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0, 1);
        step(0, 0, 0, 0, 1, 0, 1);
        step(1, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0, 1);
        step(0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Reset mid-pulse with two events queued
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 1, 1, 1, 1);
        step(1, 0, 0, 1, 1, 2, 1);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        single_pulse(1'b0);
        step(0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/event_pulse_stretcher.md
Name: event_pulse_stretcher

Overview:
- Output-side counterpart to the button debouncer. The debouncer turns a noisy level into a 1-cycle strobe; this block turns 1-cycle strobes into clean, timed pulses.
- Each queued event becomes a pulse of exactly HIGH_CYCLES, followed by a guaranteed low gap of LOW_CYCLES.
- Slow observers can therefore see every event: LED drivers, external pins, or a debouncer in another design.
- Events arriving while a pulse is in progress are counted and replayed in order; excess events are dropped and flagged.

Parameters:
- HIGH_CYCLES, 50000, pulse high time in clk cycles (>=1).
- LOW_CYCLES, 50000, minimum low gap after each pulse in clk cycles (>=1).
- COUNT_WIDTH, 16, timer width; must hold max(HIGH_CYCLES,LOW_CYCLES)-1.
- PEND_WIDTH, 4, pending-event counter width; max queued = 2^PEND_WIDTH-1.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- strobe  input  1  event request, one event per high cycle; synchronous to clk.
- clr_overflow  input  1  clears sticky overflow flag.
- pulse  output  1  stretched pulse output, registered.
- busy  output  1  high whenever state != IDLE, registered.
- pending  output  PEND_WIDTH  events queued and not yet started.
- overflow  output  1  sticky; set when an event was dropped.

Behaviour:
- Reset (rst high at an edge): state=IDLE, pulse=0, busy=0, pending=0, overflow=0, timer=0. Reset mid-pulse aborts immediately; queued events are discarded.
- States: IDLE, HIGH, LOW.
- Start condition: an event is consumed when the state is IDLE, or LOW on its final cycle, and (strobe=1 or pending!=0).
- IDLE, start condition true: next state HIGH, pulse<=1, timer<=HIGH_CYCLES-1. Latency: strobe sampled at edge N gives pulse=1 after edge N+1.
- HIGH: decrement timer. When timer==0: next state LOW, pulse<=0, timer<=LOW_CYCLES-1. Pulse is therefore high exactly HIGH_CYCLES cycles.
- LOW: decrement timer. When timer==0:
  - if the start condition holds, go directly to HIGH with no IDLE cycle;
  - otherwise go to IDLE.
- Back-to-back event period is exactly HIGH_CYCLES+LOW_CYCLES.
- pending update per cycle:
  - +1 on strobe, -1 on consume.
  - Simultaneous strobe and consume: net unchanged (strobe bypasses the queue).
  - Never underflows.
- Full queue: strobe while pending==2^PEND_WIDTH-1 with no consume that cycle drops the event; overflow<=1 at next edge; pending unchanged.
- overflow stays set until clr_overflow. If clr_overflow and a new drop occur in the same cycle, set wins.
- busy<=1 on entry to HIGH; busy<=0 on the transition LOW->IDLE. busy stays 1 across back-to-back pulses.
- HIGH_CYCLES=1 and LOW_CYCLES=1 are legal (period 2 cycles); the timer is then loaded with 0.

Test Plan (HIGH_CYCLES=3, LOW_CYCLES=2, PEND_WIDTH=2; "cycle k" = clk cycle following edge k):
- Single event: strobe=1 sampled at edge 10 only -> pulse=1 in cycles 11-13, 0 in 14-15; busy=1 cycles 11-15, 0 at 16; pending stays 0.
- Three events: strobe at edges 10,11,12 -> pending 1 then 2, draining to 0. Pulses high in cycles 11-13, 16-18, 21-23; busy continuous 11-25.
- Overflow: strobe at edges 0-4 from IDLE -> edge 0 consumed; pending 1,2,3 after edges 1-3; edge-4 strobe dropped. overflow=1 from cycle 5, exactly 4 pulses total.
- Clear race: overflow=1, clr_overflow=1 alone -> overflow=0 next cycle. clr_overflow in the same cycle as a new drop -> overflow remains 1.
- Seamless restart: strobe sampled exactly on the final LOW cycle (timer==0) -> pulse=1 on the very next cycle, busy never drops, pending stays 0.
- Reset mid-operation: rst during the second HIGH cycle with pending=2 -> next cycle pulse=0, busy=0, pending=0, overflow=0. A strobe 2 cycles after reset yields one normal 3-cycle pulse.
